// File: rtl/suma_nbit_secuencial.sv
// ----------------------------------------------------------------------------
// suma_nbit_secuencial
//   Multi-cycle N-bit adder/subtractor. A request accepted in IDLE is
//   processed D bits per clock through a D-bit ripple stage. A registered
//   carry links consecutive digits. The full result, carry-out and signed
//   overflow are published together on the completion edge, and done pulses
//   for that one cycle.
//
// Parameters
//   N : operand/result width (N >= 2)
//   D : digit width per cycle (1 <= D <= N, N % D == 0)
//
// Ports
//   clk   : clock, rising edge
//   rst_n : asynchronous reset, active low
//   start : request, sampled only while idle
//   SUB   : 0 -> S = A + B + Ci ; 1 -> S = A - B (Ci ignored)
//   A, B  : operands, sampled on an accepted start
//   Ci    : carry-in, sampled on an accepted start
//   busy  : operation in progress
//   done  : one-cycle pulse, S/Co/OV just updated
//   S     : result (N bits, truncated)
//   Co    : carry out of bit N-1 (for SUB, 1 means no borrow)
//   OV    : two's-complement signed overflow
// ----------------------------------------------------------------------------
module suma_nbit_secuencial #(
    parameter int N = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         SUB,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Ci,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] S,
    output logic         Co,
    output logic         OV
);

    localparam int NDIG = N / D;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    // Reject illegal geometries at elaboration time.
    generate
        if ((N < 2) || (D < 1) || (D > N) || ((N % D) != 0)) begin : g_bad_params
            $error("suma_nbit_secuencial: illegal N/D combination");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_r;
    logic [CW-1:0]  cnt_r;
    logic [N-1:0]   a_r;        // operand A, shifted right one digit per cycle
    logic [N-1:0]   b_r;        // effective operand B (inverted for SUB), shifted likewise
    logic           carry_r;
    logic [N-1:0]   res_r;      // result assembled from the top down as digits arrive

    logic [D-1:0]   a_dig_s;
    logic [D-1:0]   b_dig_s;
    logic [D:0]     dig_total_s;
    logic [D-1:0]   sum_dig_s;
    logic           cout_dig_s;
    logic           cin_msb_s;
    logic [N-1:0]   res_next_s;

    // Ripple stage for the current digit plus the result insertion.
    always_comb begin
        a_dig_s     = a_r[D-1:0];
        b_dig_s     = b_r[D-1:0];
        dig_total_s = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {{D{1'b0}}, carry_r};
        sum_dig_s   = dig_total_s[D-1:0];
        cout_dig_s  = dig_total_s[D];
        // Carry into the digit's top bit, recovered from its sum bit; on the
        // last digit this is the carry into bit N-1.
        cin_msb_s   = a_dig_s[D-1] ^ b_dig_s[D-1] ^ sum_dig_s[D-1];
        // New digit enters at the top; after N/D digits the LSB digit has
        // travelled down to bit 0 and the word is complete.
        res_next_s  = N'({sum_dig_s, res_r} >> D);
    end

    // Control FSM, digit datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            a_r     <= {N{1'b0}};
            b_r     <= {N{1'b0}};
            carry_r <= 1'b0;
            res_r   <= {N{1'b0}};
            busy    <= 1'b0;
            done    <= 1'b0;
            S       <= {N{1'b0}};
            Co      <= 1'b0;
            OV      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= A;
                        b_r     <= SUB ? ~B : B;
                        carry_r <= SUB ? 1'b1 : Ci;
                        cnt_r   <= CNT_ZERO;
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    a_r     <= a_r >> D;
                    b_r     <= b_r >> D;
                    res_r   <= res_next_s;
                    carry_r <= cout_dig_s;
                    if (cnt_r == LAST_DIG) begin
                        S       <= res_next_s;
                        Co      <= cout_dig_s;
                        OV      <= cin_msb_s ^ cout_dig_s;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        cnt_r   <= CNT_ZERO;
                        state_r <= IDLE;
                    end else begin
                        cnt_r   <= cnt_r + CNT_ONE;
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    cnt_r   <= CNT_ZERO;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_suma_nbit_secuencial.sv
// ----------------------------------------------------------------------------
// tb_suma_nbit_secuencial
//   Bench for suma_nbit_secuencial. The main instance is N=16, D=4. It is
//   tracked every cycle against an arithmetic model and checked against
//   hand-computed vectors. Two N=4 instances (D=1 and D=4) are swept over
//   every A, B, Ci and SUB combination.
// ----------------------------------------------------------------------------
module tb_suma_nbit_secuencial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    // main instance, N=16 D=4
    logic        start = 1'b0, SUB = 1'b0, Ci = 1'b0;
    logic [15:0] A = 16'h0000, B = 16'h0000;
    logic        busy, done, Co, OV;
    logic [15:0] S;

    // small instances, N=4, D=1 and D=4, sharing inputs
    logic        s_start = 1'b0, s_sub = 1'b0, s_ci = 1'b0;
    logic [3:0]  s_a = 4'h0, s_b = 4'h0;
    logic        busy_d1, done_d1, co_d1, ov_d1;
    logic [3:0]  s_d1;
    logic        busy_d4, done_d4, co_d4, ov_d4;
    logic [3:0]  s_d4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    suma_nbit_secuencial #(.N(16), .D(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .SUB(SUB), .A(A), .B(B), .Ci(Ci),
        .busy(busy), .done(done), .S(S), .Co(Co), .OV(OV));

    suma_nbit_secuencial #(.N(4), .D(1)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .SUB(s_sub), .A(s_a), .B(s_b), .Ci(s_ci),
        .busy(busy_d1), .done(done_d1), .S(s_d1), .Co(co_d1), .OV(ov_d1));

    suma_nbit_secuencial #(.N(4), .D(4)) dut_d4 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .SUB(s_sub), .A(s_a), .B(s_b), .Ci(s_ci),
        .busy(busy_d4), .done(done_d4), .S(s_d4), .Co(co_d4), .OV(ov_d4));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic on w-bit words; returns {ov, co, s[15:0]}.
    function automatic logic [17:0] ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                           input logic ci, input logic sub);
        int mask, av, bv, cin, tot, sv, co, ov, sa, sb, ss;
        mask = (1 << w) - 1;
        av   = int'(a) & mask;
        bv   = sub ? (~int'(b) & mask) : (int'(b) & mask);
        cin  = sub ? 1 : int'(ci);
        tot  = av + bv + cin;
        sv   = tot & mask;
        co   = (tot >> w) & 1;
        sa   = (av >> (w - 1)) & 1;
        sb   = (bv >> (w - 1)) & 1;
        ss   = (sv >> (w - 1)) & 1;
        ov   = ((sa == sb) && (ss != sa)) ? 1 : 0;
        return {ov[0], co[0], sv[15:0]};
    endfunction

    // Transaction-level model of the main instance: 4-cycle latency, no queueing.
    logic        m_busy = 1'b0, m_done = 1'b0, m_co = 1'b0, m_ov = 1'b0;
    logic [15:0] m_s = 16'h0000;
    logic [17:0] m_pend = 18'h0;
    int          m_rem = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_s <= 16'h0000; m_co <= 1'b0; m_ov <= 1'b0;
            m_rem  <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_s    <= m_pend[15:0];
                    m_co   <= m_pend[16];
                    m_ov   <= m_pend[17];
                end
            end else if (start) begin
                m_pend <= ref_op(16, A, B, Ci, SUB);
                m_rem  <= 4;
                m_busy <= 1'b1;
            end
        end
    end

    // Every-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        chk("cyc_busy", 32'(busy), 32'(m_busy));
        chk("cyc_done", 32'(done), 32'(m_done));
        chk("cyc_S",    32'(S),    32'(m_s));
        chk("cyc_Co",   32'(Co),   32'(m_co));
        chk("cyc_OV",   32'(OV),   32'(m_ov));
    end

    task automatic wait_done(input string nm);
        int c;
        c = 0;
        while (!done && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk({nm, "_done_seen"}, 32'(done), 32'(1'b1));
    endtask

    task automatic op16(input string nm, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sub,
                        input logic [15:0] es, input logic eco, input logic eov);
        @(negedge clk);
        A = a; B = b; Ci = ci; SUB = sub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(nm);
        chk({nm, "_S"},  32'(S),  32'(es));
        chk({nm, "_Co"}, 32'(Co), 32'(eco));
        chk({nm, "_OV"}, 32'(OV), 32'(eov));
    endtask

    task automatic small_op(input int a, input int b, input int ci, input int sub);
        int lat1, lat4;
        logic [17:0] r1, r4, e;
        lat1 = 0; lat4 = 0; r1 = 18'h0; r4 = 18'h0;
        @(negedge clk);
        s_a = 4'(a); s_b = 4'(b); s_ci = 1'(ci); s_sub = 1'(sub); s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (done_d1 && lat1 == 0) begin
                lat1 = c;
                r1 = {ov_d1, co_d1, 12'h000, s_d1};
            end
            if (done_d4 && lat4 == 0) begin
                lat4 = c;
                r4 = {ov_d4, co_d4, 12'h000, s_d4};
            end
        end
        e = ref_op(4, 16'(a), 16'(b), 1'(ci), 1'(sub));
        chk("sweep_d1_res", 32'(r1), 32'(e));
        chk("sweep_d4_res", 32'(r4), 32'(e));
        chk("sweep_d1_lat", 32'(lat1), 32'd4);
        chk("sweep_d4_lat", 32'(lat4), 32'd1);
    endtask

    initial begin
        int nb;
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_S",    32'(S),    32'd0);
        rst_n = 1'b1;

        // 1: zero operands, busy must last exactly four cycles
        @(negedge clk);
        A = 16'h0000; B = 16'h0000; Ci = 1'b0; SUB = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        for (int c = 0; c < 8; c++) begin
            if (busy) nb++;
            @(negedge clk);
        end
        chk("t1_busy_cycles", 32'(nb), 32'd4);
        chk("t1_S", 32'(S), 32'h0000);
        chk("t1_Co", 32'(Co), 32'd0);

        // 2..4: directed arithmetic vectors
        op16("t2a", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        op16("t2b", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        op16("t3a", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        op16("t3b", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        op16("t4",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op16("t4c", 16'h1234, 16'h0FF0, 1'b1, 1'b0, 16'h2225, 1'b0, 1'b0);

        // 5: start during RUN ignored, start in done cycle accepted
        @(negedge clk);
        A = 16'h1234; B = 16'h1111; Ci = 1'b0; SUB = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5a");
        chk("t5a_S", 32'(S), 32'h2345);
        A = 16'h0001; B = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t5b_busy", 32'(busy), 32'd1);
        wait_done("t5b");
        chk("t5b_S", 32'(S), 32'h0002);

        // 6: asynchronous reset in the middle of an operation
        op16("t6pre", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        @(negedge clk);
        A = 16'hFFFF; B = 16'h8001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_S",    32'(S),    32'd0);
        chk("t6_rst_Co",   32'(Co),   32'd0);
        chk("t6_rst_OV",   32'(OV),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nb = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || busy) nb++;
        end
        chk("t6_quiet", 32'(nb), 32'd0);
        op16("t6post", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

        // exhaustive sweep on the N=4 instances
        for (int sub = 0; sub < 2; sub++)
            for (int ci = 0; ci < 2; ci++)
                for (int a = 0; a < 16; a++)
                    for (int b = 0; b < 16; b++)
                        small_op(a, b, ci, sub);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
